// File: rtl/cu_wt_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : cu_wt_sched_if
// Description : Handshake and CU-edge bundle for the weight double-buffer
//               scheduler. master = upstream/CU side, slave = scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface cu_wt_sched_if #(
   parameter int CU_NUM_CH  = 2,
   parameter int NUM_ACT_CH = 1,
   parameter int WT_WIDTH   = 8,
   parameter int LEN_WIDTH  = 16
);
   logic                               wt_in_valid;
   logic                               wt_in_ready;
   logic [CU_NUM_CH*WT_WIDTH-1:0]      wt_in_data;
   logic                               cmd_valid;
   logic                               cmd_ready;
   logic [LEN_WIDTH-1:0]               cmd_len;
   logic [CU_NUM_CH*NUM_ACT_CH-1:0]    cmd_act_sel;
   logic                               act_valid;
   logic                               act_ready;
   logic                               cu_en;
   logic [CU_NUM_CH-1:0]               wt_load_en;
   logic [CU_NUM_CH-1:0]               wt_sel;
   logic [CU_NUM_CH*WT_WIDTH-1:0]      wt_data_out;
   logic [CU_NUM_CH*NUM_ACT_CH-1:0]    act_data_sel;
   logic                               done;

   modport master (
      output wt_in_valid, wt_in_data, cmd_valid, cmd_len, cmd_act_sel, act_valid,
      input  wt_in_ready, cmd_ready, act_ready, cu_en, wt_load_en, wt_sel,
             wt_data_out, act_data_sel, done
   );

   modport slave (
      input  wt_in_valid, wt_in_data, cmd_valid, cmd_len, cmd_act_sel, act_valid,
      output wt_in_ready, cmd_ready, act_ready, cu_en, wt_load_en, wt_sel,
             wt_data_out, act_data_sel, done
   );
endinterface
`default_nettype wire

// File: rtl/cu_wt_sched.sv
`default_nettype none
// ============================================================================
// Module      : cu_wt_sched
// Description : Weight double-buffer and compute scheduler for one CU column
//               group. Fills the shadow weight entry while the active entry
//               computes, then drains the CU pipeline and releases the entry.
//               Optional performance counters: CU_WT_SCHED_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cu_wt_sched #(
   parameter int CU_NUM_CH    = 2,
   parameter int NUM_ACT_CH   = 1,
   parameter int WT_WIDTH     = 8,
   parameter int WT_DEPTH     = 2,
   parameter int LEN_WIDTH    = 16,
   parameter int DRAIN_CYCLES = 8,
   parameter int CNT_WIDTH    = 32
) (
   input  wire logic       clk,
   input  wire logic       reset,
   cu_wt_sched_if.slave    bus
`ifdef CU_WT_SCHED_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] perf_busy_cnt,
   output logic [CNT_WIDTH-1:0] perf_stall_cnt
`endif
);

   localparam int c_BEAT_W  = (WT_DEPTH > 1) ? $clog2(WT_DEPTH) : 1;
   localparam int c_DRAIN_W = $clog2(DRAIN_CYCLES + 1);
   localparam logic [c_BEAT_W-1:0]  c_LAST_BEAT = c_BEAT_W'(WT_DEPTH - 1);
   localparam logic [c_DRAIN_W-1:0] c_DRAIN_END = c_DRAIN_W'(DRAIN_CYCLES);

   typedef enum logic [0:0] {L_IDLE = 1'b0, L_FILL = 1'b1} load_state_t;
   typedef enum logic [1:0] {C_IDLE = 2'd0, C_RUN = 2'd1, C_DRAIN = 2'd2} comp_state_t;

   load_state_t                      r_load_state, w_load_state_nxt;
   comp_state_t                      r_comp_state, w_comp_state_nxt;
   logic [c_BEAT_W-1:0]              r_beat_cnt, w_beat_cnt_nxt, w_beat_idx;
   logic [LEN_WIDTH-1:0]             r_remain, w_remain_nxt;
   logic [c_DRAIN_W-1:0]             r_drain_cnt, w_drain_cnt_nxt;
   logic [1:0]                       r_bank_full;
   logic                             r_load_ptr;
   logic                             r_comp_ptr;
   logic [CU_NUM_CH*NUM_ACT_CH-1:0]  r_act_sel;
   logic [CU_NUM_CH*WT_WIDTH-1:0]    r_wt_data;
   logic [CU_NUM_CH-1:0]             r_wt_load_en;
   logic                             w_wt_acc;
   logic                             w_cmd_acc;
   logic                             w_fill_done;
   logic                             w_release;

   // A full entry is either waiting for or under compute, so it never takes beats.
   assign bus.wt_in_ready  = ~r_bank_full[r_load_ptr];
   assign bus.cmd_ready    = (r_comp_state == C_IDLE) & r_bank_full[r_comp_ptr];
   assign bus.wt_sel       = {CU_NUM_CH{r_comp_ptr}};
   assign bus.wt_data_out  = r_wt_data;
   assign bus.wt_load_en   = r_wt_load_en;
   assign bus.act_data_sel = r_act_sel;
   assign w_wt_acc         = bus.wt_in_valid & bus.wt_in_ready;
   assign w_cmd_acc        = bus.cmd_valid & bus.cmd_ready;
   assign w_beat_idx       = (r_load_state == L_FILL) ? r_beat_cnt : '0;

   // Load FSM: count beats into the current entry and flag completion.
   always_comb begin
      w_load_state_nxt = r_load_state;
      w_beat_cnt_nxt   = r_beat_cnt;
      w_fill_done      = 1'b0;
      if (w_wt_acc) begin
         if (w_beat_idx == c_LAST_BEAT) begin
            w_fill_done      = 1'b1;
            w_beat_cnt_nxt   = '0;
            w_load_state_nxt = L_IDLE;
         end else begin
            w_beat_cnt_nxt   = w_beat_idx + c_BEAT_W'(1);
            w_load_state_nxt = L_FILL;
         end
      end
   end

   // Compute FSM: run activations, hold cu_en through the drain, then release.
   always_comb begin
      w_comp_state_nxt = r_comp_state;
      w_remain_nxt     = r_remain;
      w_drain_cnt_nxt  = r_drain_cnt;
      w_release        = 1'b0;
      bus.act_ready    = 1'b0;
      bus.cu_en        = 1'b0;
      bus.done         = 1'b0;
      case (r_comp_state)
         C_IDLE: begin
            if (w_cmd_acc) begin
               w_remain_nxt     = bus.cmd_len;
               w_drain_cnt_nxt  = '0;
               w_comp_state_nxt = (bus.cmd_len != '0) ? C_RUN : C_DRAIN;
            end
         end
         C_RUN: begin
            bus.act_ready = bus.act_valid;
            bus.cu_en     = bus.act_valid;
            if (bus.act_valid) begin
               w_remain_nxt = r_remain - LEN_WIDTH'(1);
               if (r_remain == LEN_WIDTH'(1)) begin
                  w_comp_state_nxt = C_DRAIN;
               end
            end
         end
         C_DRAIN: begin
            // The extra count after the drain is the done/release cycle.
            if (r_drain_cnt == c_DRAIN_END) begin
               bus.done         = 1'b1;
               w_release        = 1'b1;
               w_comp_state_nxt = C_IDLE;
            end else begin
               bus.cu_en       = 1'b1;
               w_drain_cnt_nxt = r_drain_cnt + c_DRAIN_W'(1);
            end
         end
         default: w_comp_state_nxt = C_IDLE;
      endcase
   end

   // State, pointer and bank-flag registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_load_state <= L_IDLE;
         r_comp_state <= C_IDLE;
         r_beat_cnt   <= '0;
         r_remain     <= '0;
         r_drain_cnt  <= '0;
         r_bank_full  <= 2'b00;
         r_load_ptr   <= 1'b0;
         r_comp_ptr   <= 1'b0;
      end else begin
         r_load_state <= w_load_state_nxt;
         r_comp_state <= w_comp_state_nxt;
         r_beat_cnt   <= w_beat_cnt_nxt;
         r_remain     <= w_remain_nxt;
         r_drain_cnt  <= w_drain_cnt_nxt;
         // Fill and release never target the same entry in one cycle.
         if (w_fill_done) begin
            r_bank_full[r_load_ptr] <= 1'b1;
            r_load_ptr              <= ~r_load_ptr;
         end
         if (w_release) begin
            r_bank_full[r_comp_ptr] <= 1'b0;
            r_comp_ptr              <= ~r_comp_ptr;
         end
      end
   end

   // Weight beat output stage and latched activation selection.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wt_load_en <= '0;
         r_wt_data    <= '0;
         r_act_sel    <= '0;
      end else begin
         r_wt_load_en <= {CU_NUM_CH{w_wt_acc}};
         if (w_wt_acc) begin
            r_wt_data <= bus.wt_in_data;
         end
         if (w_cmd_acc) begin
            r_act_sel <= bus.cmd_act_sel;
         end
      end
   end

`ifdef CU_WT_SCHED_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] r_busy_cnt;
   logic [CNT_WIDTH-1:0] r_stall_cnt;

   // Saturating busy and activation-starvation counters.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_busy_cnt  <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (bus.cu_en && (r_busy_cnt != {CNT_WIDTH{1'b1}})) begin
            r_busy_cnt <= r_busy_cnt + CNT_WIDTH'(1);
         end
         if ((r_comp_state == C_RUN) && !bus.act_valid && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign perf_busy_cnt  = r_busy_cnt;
   assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cu_wt_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_cu_wt_sched
// Description : Self-checking bench for cu_wt_sched. Bank occupancy and tile
//               progress are modelled with plain counters; beats and tiles are
//               queued as expectations and checked by an independent monitor.
//               Honours CU_WT_SCHED_PERF_CNT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cu_wt_sched;
   localparam int CU_NUM_CH    = 2;
   localparam int NUM_ACT_CH   = 1;
   localparam int WT_WIDTH     = 8;
   localparam int WT_DEPTH     = 2;
   localparam int LEN_WIDTH    = 16;
   localparam int DRAIN_CYCLES = 8;
   localparam int CNT_WIDTH    = 32;
   localparam int DW           = CU_NUM_CH * WT_WIDTH;
   localparam int SW           = CU_NUM_CH * NUM_ACT_CH;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   cu_wt_sched_if #(.CU_NUM_CH(CU_NUM_CH), .NUM_ACT_CH(NUM_ACT_CH),
                    .WT_WIDTH(WT_WIDTH), .LEN_WIDTH(LEN_WIDTH)) bus ();

`ifdef CU_WT_SCHED_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] perf_busy_cnt;
   logic [CNT_WIDTH-1:0] perf_stall_cnt;
`endif

   cu_wt_sched #(
      .CU_NUM_CH(CU_NUM_CH), .NUM_ACT_CH(NUM_ACT_CH), .WT_WIDTH(WT_WIDTH),
      .WT_DEPTH(WT_DEPTH), .LEN_WIDTH(LEN_WIDTH), .DRAIN_CYCLES(DRAIN_CYCLES),
      .CNT_WIDTH(CNT_WIDTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef CU_WT_SCHED_PERF_CNT_EN
      ,
      .perf_busy_cnt  (perf_busy_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   typedef struct {
      int            len;
      logic [SW-1:0] sel;
      bit            bank;
   } tile_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [DW-1:0] q_wt[$];
   tile_t       q_tile[$];
   int          act_mode = 3;

   // Reference model state
   int            m_full, m_fill, m_rem, m_drain;
   bit            m_busy, m_bank;
   logic [SW-1:0] m_sel;
   longint        m_pbusy, m_pstall;
   bit            rst_q = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Predictor: per-cycle expectations from bank/tile counters, and queueing
   // of accepted beats and commands.
   always @(negedge clk) begin
      bit e_wr, e_cr, e_run, e_ar, e_cu, e_done, fill_inc;
      if (!reset) begin
         rst_q = 1'b1;
      end else begin
         if (rst_q) begin
            rst_q = 1'b0;
            m_full = 0; m_fill = 0; m_rem = 0; m_drain = 0;
            m_busy = 1'b0; m_bank = 1'b0; m_sel = '0;
            m_pbusy = 0; m_pstall = 0;
            q_wt.delete();
            q_tile.delete();
            check("rst_wt_load_en", bus.wt_load_en, 0);
            check("rst_wt_data_out", bus.wt_data_out, 0);
         end
         e_wr   = (m_full < 2);
         e_cr   = !m_busy && (m_full > 0);
         e_run  = m_busy && (m_rem > 0);
         e_ar   = e_run && bus.act_valid;
         e_cu   = e_ar || (m_busy && m_rem == 0 && m_drain > 0);
         e_done = m_busy && m_rem == 0 && m_drain == 0;
         check("wt_in_ready", bus.wt_in_ready, e_wr);
         check("cmd_ready", bus.cmd_ready, e_cr);
         check("act_ready", bus.act_ready, e_ar);
         check("cu_en", bus.cu_en, e_cu);
         check("done", bus.done, e_done);
         check("wt_sel", bus.wt_sel, {CU_NUM_CH{m_bank}});
         check("act_data_sel", bus.act_data_sel, m_sel);
`ifdef CU_WT_SCHED_PERF_CNT_EN
         check("perf_busy_cnt", perf_busy_cnt, m_pbusy);
         check("perf_stall_cnt", perf_stall_cnt, m_pstall);
`endif
         if (e_cu) m_pbusy++;
         if (e_run && !bus.act_valid) m_pstall++;
         fill_inc = 1'b0;
         if (bus.wt_in_valid && e_wr) begin
            q_wt.push_back(bus.wt_in_data);
            m_fill++;
            if (m_fill == WT_DEPTH) begin
               m_fill   = 0;
               fill_inc = 1'b1;
            end
         end
         if (e_done) begin
            m_busy = 1'b0;
            m_full--;
            m_bank = ~m_bank;
         end else if (bus.cmd_valid && e_cr) begin
            q_tile.push_back('{len: int'(bus.cmd_len), sel: bus.cmd_act_sel, bank: m_bank});
            m_busy  = 1'b1;
            m_rem   = int'(bus.cmd_len);
            m_drain = DRAIN_CYCLES;
            m_sel   = bus.cmd_act_sel;
         end else if (m_busy) begin
            if (m_rem > 0) begin
               if (bus.act_valid) m_rem--;
            end else begin
               m_drain--;
            end
         end
         if (fill_inc) m_full++;
      end
   end

   // Monitor: pops expectations when the DUT presents a weight beat or done.
   int mon_cu, mon_act;
   always @(negedge clk) begin
      logic [DW-1:0] exp_wt;
      tile_t         t;
      if (!reset) begin
         mon_cu  = 0;
         mon_act = 0;
      end else begin
         if (bus.wt_load_en != '0) begin
            check("wt_load_en_all", bus.wt_load_en, {CU_NUM_CH{1'b1}});
            if (q_wt.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL wt_unexpected: load pulse with data 0x%0h, none required", bus.wt_data_out);
            end else begin
               exp_wt = q_wt.pop_front();
               check("wt_data_out", bus.wt_data_out, exp_wt);
            end
         end
         if (bus.cu_en)     mon_cu++;
         if (bus.act_ready) mon_act++;
         if (bus.done) begin
            if (q_tile.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL done_unexpected: done pulse with 0 tiles pending, 1 required");
            end else begin
               t = q_tile.pop_front();
               check("tile_cu_en_cycles", mon_cu, t.len + DRAIN_CYCLES);
               check("tile_acts", mon_act, t.len);
               check("tile_bank", bus.wt_sel, {CU_NUM_CH{t.bank}});
               check("tile_act_sel", bus.act_data_sel, t.sel);
            end
            mon_cu  = 0;
            mon_act = 0;
         end
      end
   end

   // Activation source pattern.
   initial begin
      bus.act_valid = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (act_mode)
            0:       bus.act_valid = 1'b1;
            1:       bus.act_valid = ~bus.act_valid;
            2:       bus.act_valid = ($urandom_range(0, 2) != 0);
            default: bus.act_valid = 1'b0;
         endcase
      end
   end

   task automatic send_beats(input int n);
      int got;
      got = 0;
      bus.wt_in_valid = 1'b1;
      bus.wt_in_data  = DW'($urandom);
      for (int k = 0; k < 400 && got < n; k++) begin
         @(negedge clk);
         if (bus.wt_in_ready) begin
            got++;
            @(posedge clk); #1;
            bus.wt_in_data = DW'($urandom);
         end
      end
      bus.wt_in_valid = 1'b0;
      if (got < n) begin
         n_tests++; n_fail++;
         $display("FAIL beat_timeout: accepted %0d beats, required %0d", got, n);
      end
   endtask

   task automatic send_cmd(input int len, input logic [SW-1:0] sel);
      bit ok;
      ok = 1'b0;
      bus.cmd_valid   = 1'b1;
      bus.cmd_len     = LEN_WIDTH'(len);
      bus.cmd_act_sel = sel;
      for (int k = 0; k < 400 && !ok; k++) begin
         @(negedge clk);
         if (bus.cmd_ready) begin
            ok = 1'b1;
            @(posedge clk); #1;
         end
      end
      bus.cmd_valid = 1'b0;
      if (!ok) begin
         n_tests++; n_fail++;
         $display("FAIL cmd_timeout: cmd_ready got 0 expected 1 within bound");
      end
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 400 && !seen; k++) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      if (!seen) begin
         n_tests++; n_fail++;
         $display("FAIL done_timeout: done got 0 expected 1 within bound");
      end
      @(posedge clk); #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.wt_in_valid = 1'b0;
      bus.wt_in_data  = '0;
      bus.cmd_valid   = 1'b0;
      bus.cmd_len     = '0;
      bus.cmd_act_sel = '0;
      cycles(3);
      reset = 1'b1;

      // Two fills with no commands; the 5th and 6th beats must be refused.
      for (int i = 0; i < 6; i++) begin
         bus.wt_in_valid = 1'b1;
         bus.wt_in_data  = (i % 2 == 0) ? DW'(16'h1111) : DW'(16'h2222);
         cycles(1);
      end
      bus.wt_in_valid = 1'b0;
      cycles(2);

      // Constant activations, length 5.
      act_mode = 0;
      send_cmd(5, SW'(1));
      wait_done();

      // Toggling activations, length 3.
      act_mode = 1;
      send_cmd(3, SW'(2));
      wait_done();

      // Shadow fill overlapping compute; back-to-back commands.
      act_mode = 0;
      send_beats(2);
      fork
         send_beats(4);
         begin
            send_cmd(4, SW'(1));
            send_cmd(2, SW'(3));
         end
      join
      wait_done();

      // Zero-length command goes straight to drain.
      send_cmd(0, SW'(2));
      wait_done();

      // Randomised traffic.
      act_mode = 2;
      for (int c = 0; c < 3000; c++) begin
         bus.wt_in_valid = ($urandom_range(0, 2) != 0);
         bus.wt_in_data  = DW'($urandom);
         bus.cmd_valid   = ($urandom_range(0, 3) == 0);
         bus.cmd_len     = LEN_WIDTH'($urandom_range(0, 6));
         bus.cmd_act_sel = SW'($urandom);
         cycles(1);
      end
      bus.wt_in_valid = 1'b0;
      bus.cmd_valid   = 1'b0;
      act_mode = 0;
      cycles(60);
      reset = 1'b0;
      cycles(2);
      reset = 1'b1;

      // Reset during C_RUN with a half-filled shadow entry.
      send_beats(2);
      send_cmd(20, SW'(3));
      cycles(2);
      send_beats(1);
      reset = 1'b0;
      cycles(1);
      reset = 1'b1;
      bus.cmd_valid   = 1'b1;
      bus.cmd_len     = LEN_WIDTH'(2);
      bus.cmd_act_sel = SW'(1);
      send_beats(1);
      cycles(4);
      bus.cmd_valid = 1'b0;
      send_beats(1);
      send_cmd(2, SW'(1));
      wait_done();
      cycles(20);

      check("end_wt_queue_empty", q_wt.size(), 0);
      check("end_tile_queue_empty", q_tile.size(), 0);
      check("end_model_idle", m_busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
